// File: rtl/uart_pkg.sv
// Shared state encoding and frame-level constants for the UART transmit path.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_t;

   localparam logic PAR_EVEN  = 1'b0;
   localparam logic PAR_ODD   = 1'b1;
   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_tx_if.sv
// Host-side handshake and serial-line bundle for uart_tx.
interface uart_tx_if #(
   parameter int DATA_WIDTH = 8
);

   logic [DATA_WIDTH-1:0] p_data;
   logic                  data_valid;
   logic                  par_en;
   logic                  par_typ;
   logic                  tx_out;
   logic                  busy;
   logic                  tx_done;

   modport master (
      output p_data, data_valid, par_en, par_typ,
      input  tx_out, busy, tx_done
   );

   modport slave (
      input  p_data, data_valid, par_en, par_typ,
      output tx_out, busy, tx_done
   );

endinterface

// File: rtl/uart_tx_baud_cnt.sv
// Bit-period divider: counts system clocks within one serial bit and flags the last one.
module uart_tx_baud_cnt #(
   parameter int CLKS_PER_BIT = 16,
   parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
   input  logic             uart_tx_clk,
   input  logic             uart_tx_rst,
   input  logic             clear,
   output logic [CNT_W-1:0] count,
   output logic             bit_tick
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

   // Held at zero while the transmitter idles so every frame starts on a fresh bit period
   always_ff @(posedge uart_tx_clk) begin
      if (uart_tx_rst || clear) begin
         count <= '0;
      end else if (count == LAST_CNT) begin
         count <= '0;
      end else begin
         count <= count + 1'b1;
      end
   end

   assign bit_tick = !clear && (count == LAST_CNT);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional parity, one stop bit.
// Parity support is compiled in only when UART_TX_PARITY_EN is defined.
module uart_tx #(
   parameter int DATA_WIDTH   = 8,
   parameter int CLKS_PER_BIT = 16
) (
   input logic       uart_tx_clk,
   input logic       uart_tx_rst,
   uart_tx_if.slave  bus
);

   import uart_pkg::*;

   localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);
   localparam logic [CNT_W-1:0] DONE_CNT = CNT_W'(CLKS_PER_BIT - 2);

   tx_state_t             state;
   logic [DATA_WIDTH-1:0] shift_reg;
   logic [BIT_W-1:0]      bit_cnt;
   logic [CNT_W-1:0]      baud_cnt;
   logic                  bit_tick;
   logic                  baud_clear;
   logic                  tx_out_r;
   logic                  busy_r;
   logic                  tx_done_r;

`ifdef UART_TX_PARITY_EN
   logic par_en_r;
   logic par_bit_r;
`else
   logic unused_par_cfg;
   assign unused_par_cfg = ^{bus.par_en, bus.par_typ};
`endif

   assign baud_clear = (state == IDLE);

   uart_tx_baud_cnt #(
      .CLKS_PER_BIT (CLKS_PER_BIT),
      .CNT_W        (CNT_W)
   ) u_baud_cnt (
      .uart_tx_clk (uart_tx_clk),
      .uart_tx_rst (uart_tx_rst),
      .clear       (baud_clear),
      .count       (baud_cnt),
      .bit_tick    (bit_tick)
   );

   // Frame sequencer; tx_out is loaded with the next slot's value on each bit boundary
   always_ff @(posedge uart_tx_clk) begin
      if (uart_tx_rst) begin
         state     <= IDLE;
         shift_reg <= '0;
         bit_cnt   <= '0;
         tx_out_r  <= STOP_BIT;
         busy_r    <= 1'b0;
         tx_done_r <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par_en_r  <= 1'b0;
         par_bit_r <= 1'b0;
`endif
      end else begin
         tx_done_r <= (state == STOP) && (baud_cnt == DONE_CNT);
         case (state)
            IDLE: begin
               if (bus.data_valid) begin
                  shift_reg <= bus.p_data;
                  bit_cnt   <= '0;
                  tx_out_r  <= START_BIT;
                  busy_r    <= 1'b1;
                  state     <= START;
`ifdef UART_TX_PARITY_EN
                  par_en_r  <= bus.par_en;
                  par_bit_r <= (^bus.p_data) ^ (bus.par_typ == PAR_ODD);
`endif
               end
            end
            START: begin
               if (bit_tick) begin
                  tx_out_r <= shift_reg[0];
                  state    <= DATA;
               end
            end
            DATA: begin
               if (bit_tick) begin
                  if (bit_cnt == LAST_BIT) begin
                     bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                     if (par_en_r) begin
                        tx_out_r <= par_bit_r;
                        state    <= PARITY;
                     end else begin
                        tx_out_r <= STOP_BIT;
                        state    <= STOP;
                     end
`else
                     tx_out_r <= STOP_BIT;
                     state    <= STOP;
`endif
                  end else begin
                     tx_out_r  <= shift_reg[1];
                     shift_reg <= shift_reg >> 1;
                     bit_cnt   <= bit_cnt + 1'b1;
                  end
               end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
               if (bit_tick) begin
                  tx_out_r <= STOP_BIT;
                  state    <= STOP;
               end
            end
`endif
            STOP: begin
               if (bit_tick) begin
                  busy_r <= 1'b0;
                  state  <= IDLE;
               end
            end
            default: begin
               tx_out_r <= STOP_BIT;
               busy_r   <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end

   assign bus.tx_out  = tx_out_r;
   assign bus.busy    = busy_r;
   assign bus.tx_done = tx_done_r;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: table of frames plus hold-off and mid-frame reset sequences.
// Expected frame lengths follow UART_TX_PARITY_EN when the bench is built with it.
module tb_uart_tx;

   import uart_pkg::*;

   localparam int DW  = 8;
   localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
   localparam bit PAR_BUILT = 1'b1;
`else
   localparam bit PAR_BUILT = 1'b0;
`endif
   localparam int LEN_NP = (2 + DW) * CPB;
   localparam int LEN_P  = PAR_BUILT ? (3 + DW) * CPB : LEN_NP;
   localparam int NV     = 7;

   typedef struct {
      logic [DW-1:0] data;
      logic          pe;
      logic          pt;
      logic          exp_par;
      int            exp_len;
   } vec_t;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   logic exp_q[$];
   vec_t vecs[NV];
   vec_t hold_vec;

   uart_tx_if #(.DATA_WIDTH(DW)) bus ();

   uart_tx #(
      .DATA_WIDTH   (DW),
      .CLKS_PER_BIT (CPB)
   ) dut (
      .uart_tx_clk (clk),
      .uart_tx_rst (rst),
      .bus         (bus)
   );

   // Free-running system clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop if the sequence below stalls somewhere unforeseen
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard push of the expected slot sequence of one frame
   task automatic pushExpected(input vec_t v);
      exp_q.push_back(START_BIT);
      for (int i = 0; i < DW; i++) exp_q.push_back(v.data[i]);
      if (PAR_BUILT && v.pe) exp_q.push_back(v.exp_par);
      exp_q.push_back(STOP_BIT);
   endtask

   // Called at a negedge while idle; returns at the negedge of the frame's first cycle
   task automatic applyStimulus(input vec_t v);
      bus.p_data     = v.data;
      bus.par_en     = v.pe;
      bus.par_typ    = v.pt;
      bus.data_valid = 1'b1;
      pushExpected(v);
      @(negedge clk);
      bus.data_valid = 1'b0;
   endtask

   // Walks one frame cycle by cycle, popping one expected bit per slot
   task automatic checkOutput(input int exp_len);
      int   cyc;
      logic exp_bit;
      cyc     = 0;
      exp_bit = 1'bx;
      while (bus.busy === 1'b1 && cyc < 200) begin
         if (cyc % CPB == 0) exp_bit = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
         chk("tx_bit", bus.tx_out, exp_bit);
         chk("tx_done", bus.tx_done, (cyc == exp_len - 1));
         cyc++;
         @(negedge clk);
      end
      chk("frame_len", cyc, exp_len);
      chk("sb_left", exp_q.size(), 0);
      chk("idle_tx", bus.tx_out, STOP_BIT);
      chk("idle_busy", bus.busy, 1'b0);
      chk("idle_done", bus.tx_done, 1'b0);
      exp_q.delete();
   endtask

   initial begin
      checks         = 0;
      errors         = 0;
      rst            = 1'b1;
      bus.p_data     = '0;
      bus.data_valid = 1'b0;
      bus.par_en     = 1'b0;
      bus.par_typ    = 1'b0;

      vecs[0] = '{8'hA5, 1'b0, PAR_EVEN, 1'b0, LEN_NP};
      vecs[1] = '{8'hA5, 1'b1, PAR_EVEN, 1'b0, LEN_P};
      vecs[2] = '{8'h01, 1'b1, PAR_EVEN, 1'b1, LEN_P};
      vecs[3] = '{8'h01, 1'b1, PAR_ODD,  1'b0, LEN_P};
      vecs[4] = '{8'hFF, 1'b1, PAR_ODD,  1'b1, LEN_P};
      vecs[5] = '{8'h00, 1'b0, PAR_ODD,  1'b0, LEN_NP};
      vecs[6] = '{8'h3C, 1'b1, PAR_EVEN, 1'b0, LEN_P};

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_tx_out", bus.tx_out, 1'b1);
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_done", bus.tx_done, 1'b0);
      rst = 1'b0;
      @(negedge clk);

      // Reset and request in the same cycle: nothing may be captured
      rst            = 1'b1;
      bus.p_data     = 8'hFF;
      bus.data_valid = 1'b1;
      @(negedge clk);
      rst            = 1'b0;
      bus.data_valid = 1'b0;
      chk("rst_vs_valid_busy", bus.busy, 1'b0);
      chk("rst_vs_valid_tx", bus.tx_out, 1'b1);
      @(negedge clk);
      chk("rst_vs_valid_after", bus.busy, 1'b0);

      for (int i = 0; i < NV; i++) begin
         applyStimulus(vecs[i]);
         checkOutput(vecs[i].exp_len);
         @(negedge clk);
      end

      // Request held high with new data during a frame is ignored until the first idle cycle
      applyStimulus(vecs[0]);
      bus.data_valid = 1'b1;
      bus.p_data     = 8'h3C;
      bus.par_en     = 1'b1;
      bus.par_typ    = PAR_ODD;
      checkOutput(LEN_NP);
      hold_vec = '{8'h3C, 1'b1, PAR_ODD, 1'b1, LEN_P};
      pushExpected(hold_vec);
      @(negedge clk);
      bus.data_valid = 1'b0;
      chk("hold_accept_busy", bus.busy, 1'b1);
      checkOutput(LEN_P);
      @(negedge clk);

      // Reset in the middle of data bit 3 abandons the frame
      applyStimulus(vecs[0]);
      repeat (17) @(negedge clk);
      chk("pre_rst_busy", bus.busy, 1'b1);
      chk("pre_rst_bit3", bus.tx_out, vecs[0].data[3]);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mid_rst_tx", bus.tx_out, 1'b1);
      chk("mid_rst_busy", bus.busy, 1'b0);
      chk("mid_rst_done", bus.tx_done, 1'b0);
      exp_q.delete();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("post_rst_done", bus.tx_done, 1'b0);
         chk("post_rst_busy", bus.busy, 1'b0);
      end
      applyStimulus('{8'h5A, 1'b0, PAR_EVEN, 1'b0, LEN_NP});
      checkOutput(LEN_NP);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
